// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle-latency imem reads,
// and a small {PC, instr} prefetch queue feeding decode, with stall and branch flush.
module fetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          running;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   occupancy;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pcd_hold;
    logic [31:0]   pcp4_hold;
    logic [31:0]   head_pc;
    logic          push;
    logic          pop;

    // Credit: queued entries plus the outstanding read may never exceed the queue size.
    assign occupancy = count + {{PW{1'b0}}, inflight};
    assign imem_req  = !rst && !PCSrcE && (occupancy < (PW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign push = inflight && !PCSrcE;
    assign pop  = ValidD && !StallD && !PCSrcE;

    assign ValidD   = (count != '0);
    assign head_pc  = pc_mem[rd_ptr];
    assign PCD      = ValidD ? head_pc : pcd_hold;
    assign PCPlus4D = ValidD ? head_pc + 32'd4 : pcp4_hold;
    // InstrD reads zero only between reset and the first clock edge after it.
    assign InstrD   = ValidD ? instr_mem[rd_ptr] : (running ? NOP : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            running     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pcd_hold    <= '0;
            pcp4_hold   <= '0;
        end else begin
            running   <= 1'b1;
            pcd_hold  <= PCD;
            pcp4_hold <= PCPlus4D;
            if (PCSrcE) begin
                fetch_pc <= PCTargetE & ~32'h3;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= imem_req;
                if (imem_req) begin
                    fetch_pc    <= fetch_pc + 32'd4;
                    inflight_pc <= fetch_pc;
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer: a scoreboard queue of accepted fetch
// addresses predicts request gating, queue occupancy and the decode-side stream.
module tb_fetch_prefetch_buffer;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [31:0] sbq[$];
    logic        inflight_m = 1'b0;
    logic        running_m  = 1'b0;
    logic [31:0] exp_pc     = '0;
    logic [31:0] last_pcd   = '0;
    logic [31:0] last_pcp4  = '0;

    fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ValidD     (ValidD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word index as the instruction, junk when idle.
    always @(posedge clk)
        imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic exp_req;
        logic exp_valid;
        if (rst) begin
            sbq.delete();
            inflight_m = 1'b0;
            running_m  = 1'b0;
            exp_pc     = 32'h0;
            last_pcd   = '0;
            last_pcp4  = '0;
        end else begin
            exp_req   = !PCSrcE && (sbq.size() < int'(DEPTH));
            exp_valid = sbq.size() > int'(inflight_m);
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            check("ValidD", {31'b0, ValidD}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("PCD", PCD, sbq[0]);
                check("InstrD", InstrD, sbq[0] >> 2);
                check("PCPlus4D", PCPlus4D, sbq[0] + 32'd4);
                last_pcd  = sbq[0];
                last_pcp4 = sbq[0] + 32'd4;
                if (!StallD && !PCSrcE) begin
                    void'(sbq.pop_front());
                    n_pops++;
                end
            end else begin
                check("InstrD_empty", InstrD, running_m ? NOP : 32'h0);
                check("PCD_hold", PCD, last_pcd);
                check("PCPlus4D_hold", PCPlus4D, last_pcp4);
            end
            if (PCSrcE) begin
                sbq.delete();
                inflight_m = 1'b0;
                exp_pc     = PCTargetE & ~32'h3;
            end else begin
                inflight_m = exp_req;
                if (exp_req) begin
                    check("imem_addr", imem_addr, exp_pc);
                    sbq.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            running_m = 1'b1;
        end
    end

    initial begin
        rst       = 1'b1;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        StallD    = 1'b0;
        #1;
        check("rst_ValidD", {31'b0, ValidD}, 32'h0);
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_InstrD", InstrD, 32'h0);
        check("rst_PCD", PCD, 32'h0);
        check("rst_PCPlus4D", PCPlus4D, 32'h0);
        cycles(3);
        rst = 1'b0;

        // Streaming, then a long stall that fills the queue.
        cycles(12);
        StallD = 1'b1;
        cycles(10);
        StallD = 1'b0;
        cycles(10);

        // Flush with a partially filled queue.
        StallD = 1'b1;
        cycles(3);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        cycles(1);
        PCSrcE = 1'b0;
        StallD = 1'b0;
        cycles(8);

        // Back-to-back redirects: only the last target survives.
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        cycles(1);
        PCTargetE = 32'h300;
        cycles(1);
        PCSrcE = 1'b0;
        cycles(8);

        // Misaligned target and address wrap past 2^32.
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFF6;
        cycles(1);
        PCSrcE = 1'b0;
        cycles(10);

        // Random stalls and redirects exercise pointer wrap and push+pop at every fill level.
        for (int i = 0; i < 400; i++) begin
            StallD    = ($urandom_range(0, 2) == 0);
            PCSrcE    = ($urandom_range(0, 24) == 0);
            PCTargetE = $urandom;
            cycles(1);
        end
        PCSrcE = 1'b0;
        StallD = 1'b0;
        cycles(6);

        // Asynchronous reset while a read is outstanding.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ValidD", {31'b0, ValidD}, 32'h0);
        check("arst_imem_req", {31'b0, imem_req}, 32'h0);
        check("arst_InstrD", InstrD, 32'h0);
        check("arst_PCD", PCD, 32'h0);
        check("arst_PCPlus4D", PCPlus4D, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(20);

        check("pops_seen", {31'b0, (n_pops > 150)}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
